uart_word_tx: RTL and testbench

Transmit-side word serializer for the UART link. Accepts 32-bit words over a valid/ready interface and buffers them in a small FIFO. Splits each word into four bytes, least-significant first, and feeds them one at a time to the `uart_send` byte transmitter through its `uart_en`/`uart_din`/`uart_tx_busy` handshake. It is the mirror of the receive path's 4-byte reassembly, so a word sent here is rebuilt unchanged on the far side.

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_word_fifo.sv | 56 +++++
 rtl/uart_word_tx.sv | 98 +++++++++
 tb/tb_uart_word_tx.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART word transmit path.
package uart_pkg;

  localparam int BYTE_W         = 8;
  localparam int WORD_W         = 32;
  localparam int BYTES_PER_WORD = WORD_W / BYTE_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    REQ  = 2'd2,
    WAIT = 2'd3
  } uart_state_t;

  function automatic int bytes_per_word(input int width);
    return width / BYTE_W;
  endfunction

endpackage

// File: rtl/uart_word_fifo.sv
// Word FIFO with registered full/empty/count/ready and first-word-fall-through read.
module uart_word_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          sys_clk,
  input  logic                          sys_rst,
  input  logic                          push,
  input  logic [DATA_WIDTH-1:0]         wr_data,
  input  logic                          pop,
  output logic [DATA_WIDTH-1:0]         rd_data,
  output logic                          empty,
  output logic                          ready,
  output logic [$clog2(FIFO_DEPTH):0]   count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic                  full;
  logic                  push_ok;
  logic                  pop_ok;
  logic [CW-1:0]         count_nxt;

  assign push_ok   = push && !full;
  assign pop_ok    = pop && !empty;
  assign count_nxt = count + CW'(push_ok) - CW'(pop_ok);
  assign rd_data   = mem[rd_ptr];

  always_ff @(posedge sys_clk) begin
    if (push_ok) mem[wr_ptr] <= wr_data;
  end

  // ready is held low through reset and tracks !full from the first edge after release
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
      ready  <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_nxt;
      full  <= (count_nxt == CW'(FIFO_DEPTH));
      empty <= (count_nxt == '0);
      ready <= (count_nxt != CW'(FIFO_DEPTH));
    end
  end

endmodule

// File: rtl/uart_word_tx.sv
// Word-to-byte serializer feeding uart_send, LSB first, with a word FIFO in front.
module uart_word_tx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                        sys_clk,
  input  logic                        sys_rst,
  input  logic                        s_valid,
  input  logic [DATA_WIDTH-1:0]       s_data,
  output logic                        s_ready,
  output logic                        uart_en,
  output logic [BYTE_W-1:0]           uart_din,
  input  logic                        uart_tx_busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        idle,
  output uart_state_t                 dbg_state
);

  localparam int BYTES = bytes_per_word(DATA_WIDTH);
  localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES - 1);

  // Handshake: a word moves on every sys_clk edge with s_valid && s_ready;
  // s_ready is registered and never depends on the same-cycle pop.
  uart_state_t           state, state_nxt;
  logic [DATA_WIDTH-1:0] shift, shift_nxt;
  logic [IDX_W-1:0]      byte_idx, byte_idx_nxt;
  logic [DATA_WIDTH-1:0] fifo_rd_data;
  logic                  fifo_empty;
  logic                  pop;

  uart_word_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .push    (s_valid && s_ready),
    .wr_data (s_data),
    .pop     (pop),
    .rd_data (fifo_rd_data),
    .empty   (fifo_empty),
    .ready   (s_ready),
    .count   (fifo_count)
  );

  always_comb begin
    state_nxt    = state;
    shift_nxt    = shift;
    byte_idx_nxt = byte_idx;
    pop          = 1'b0;
    case (state)
      IDLE: if (!fifo_empty && !uart_tx_busy) state_nxt = LOAD;
      LOAD: begin
        pop          = 1'b1;
        shift_nxt    = fifo_rd_data;
        byte_idx_nxt = '0;
        state_nxt    = REQ;
      end
      REQ:  if (uart_tx_busy) state_nxt = WAIT;
      WAIT: begin
        if (!uart_tx_busy) begin
          if (byte_idx == LAST_IDX) begin
            state_nxt = IDLE;
          end else begin
            shift_nxt    = shift >> BYTE_W;
            byte_idx_nxt = byte_idx + IDX_W'(1);
            state_nxt    = REQ;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // uart_en is high exactly while in REQ, so each byte gets a fresh rising edge
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state    <= IDLE;
      shift    <= '0;
      byte_idx <= '0;
      uart_en  <= 1'b0;
      uart_din <= '0;
    end else begin
      state    <= state_nxt;
      shift    <= shift_nxt;
      byte_idx <= byte_idx_nxt;
      uart_en  <= (state_nxt == REQ);
      if (state_nxt == REQ) uart_din <= shift_nxt[BYTE_W-1:0];
    end
  end

  assign idle      = fifo_empty && (state == IDLE);
  assign dbg_state = state;

endmodule

// File: tb/tb_uart_word_tx.sv
// Directed bench for uart_word_tx with a uart_send busy model and byte scoreboard.
module tb_uart_word_tx;
  import uart_pkg::*;

  localparam int RISE_DLY  = 3;
  localparam int FRAME_LEN = 20;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        s_valid = 1'b0;
  logic [31:0] s_data  = '0;
  logic        s_ready;
  logic        uart_en;
  logic [7:0]  uart_din;
  logic        uart_tx_busy;
  logic [3:0]  fifo_count;
  logic        idle;
  uart_state_t dbg_state;

  logic model_busy = 1'b0;
  logic hold_busy  = 1'b0;
  assign uart_tx_busy = model_busy | hold_busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int         width_q[$];
  int         gap_q[$];
  int         rises = 0;
  int         cyc = 0, last_fall = 0, width = 0, rise_cnt = 0, frame = 0;
  logic       en_prev = 1'b0;

  uart_word_tx dut (
    .sys_clk      (sys_clk),
    .sys_rst      (sys_rst),
    .s_valid      (s_valid),
    .s_data       (s_data),
    .s_ready      (s_ready),
    .uart_en      (uart_en),
    .uart_din     (uart_din),
    .uart_tx_busy (uart_tx_busy),
    .fifo_count   (fifo_count),
    .idle         (idle),
    .dbg_state    (dbg_state)
  );

  // clock / reset
  always #5 sys_clk = ~sys_clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // uart_send model: busy rises RISE_DLY cycles after uart_en, stays FRAME_LEN cycles
  always @(negedge sys_clk) begin
    cyc++;
    if (uart_en && !en_prev) begin
      rises++;
      gap_q.push_back(cyc - last_fall);
    end
    if (uart_en) width++;
    else if (width != 0) begin
      width_q.push_back(width);
      width = 0;
    end
    en_prev = uart_en;
    if (model_busy) begin
      frame--;
      if (frame == 0) begin
        model_busy = 1'b0;
        last_fall  = cyc;
      end
    end else if (uart_en) begin
      rise_cnt++;
      if (rise_cnt == RISE_DLY) begin
        model_busy = 1'b1;
        frame      = FRAME_LEN;
        rise_cnt   = 0;
        got_q.push_back(uart_din);
      end
    end else begin
      rise_cnt = 0;
    end
  end

  task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // driver tasks
  task automatic push_word(input logic [31:0] data, input int budget, output bit ok);
    @(negedge sys_clk);
    s_valid = 1'b1;
    s_data  = data;
    ok      = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      ok = s_ready;
      @(negedge sys_clk);
    end
    s_valid = 1'b0;
  endtask

  task automatic push_exp(input logic [31:0] data);
    bit ok;
    push_word(data, 20, ok);
    chk_eq("push_accept", 32'(ok), 32'd1);
    for (int b = 0; b < 4; b++) exp_q.push_back(data[8*b +: 8]);
  endtask

  task automatic compare_bytes(input string tag, input int base);
    int i;
    i = 0;
    while (got_q.size() < base + exp_q.size() && i < 3000) begin
      @(negedge sys_clk);
      i++;
    end
    repeat (40) @(negedge sys_clk);
    chk_eq({tag, "_nbytes"}, 32'(got_q.size() - base), 32'(exp_q.size()));
    for (int k = 0; k < exp_q.size(); k++)
      if (base + k < got_q.size())
        chk_eq({tag, "_byte"}, 32'(got_q[base + k]), 32'(exp_q[k]));
    exp_q.delete();
  endtask

  function automatic logic [31:0] seq_word(input int b);
    return {8'(b + 3), 8'(b + 2), 8'(b + 1), 8'(b)};
  endfunction

  initial begin
    bit ok;
    int base, rbase, wbase, gbase;

    // reset state
    repeat (3) @(negedge sys_clk);
    chk_eq("rst_en", 32'(uart_en), 32'd0);
    chk_eq("rst_din", 32'(uart_din), 32'h00);
    chk_eq("rst_count", 32'(fifo_count), 32'd0);
    chk_eq("rst_idle", 32'(idle), 32'd1);
    chk_eq("rst_ready", 32'(s_ready), 32'd0);
    sys_rst = 1'b0;
    @(negedge sys_clk);
    chk_eq("post_rst_ready", 32'(s_ready), 32'd1);

    // single word: latency, byte order, pulse widths
    base = got_q.size(); rbase = rises; wbase = width_q.size();
    push_exp(32'hDDCCBBAA);
    chk_eq("lat_n0_en", 32'(uart_en), 32'd0);
    @(negedge sys_clk);
    chk_eq("lat_n1_state", 32'(dbg_state), 32'(LOAD));
    chk_eq("lat_n1_en", 32'(uart_en), 32'd0);
    @(negedge sys_clk);
    chk_eq("lat_n2_en", 32'(uart_en), 32'd1);
    chk_eq("lat_n2_din", 32'(uart_din), 32'hAA);
    compare_bytes("single", base);
    chk_eq("single_rises", 32'(rises - rbase), 32'd4);
    chk_eq("single_npulse", 32'(width_q.size() - wbase), 32'd4);
    for (int k = wbase; k < width_q.size(); k++) chk_eq("single_width", 32'(width_q[k]), 32'd3);
    chk_eq("single_idle", 32'(idle), 32'd1);

    // fill while busy held: 8 accepted, 9th waits for the first pop
    base = got_q.size();
    hold_busy = 1'b1;
    for (int w = 0; w < 8; w++) push_exp(seq_word(4 * w));
    chk_eq("full_ready", 32'(s_ready), 32'd0);
    chk_eq("full_count", 32'(fifo_count), 32'd8);
    chk_eq("full_no_en", 32'(uart_en), 32'd0);
    for (int b = 0; b < 4; b++) exp_q.push_back(8'(32 + b));
    fork
      push_word(seq_word(32), 60, ok);
      begin
        @(negedge sys_clk);
        hold_busy = 1'b0;
      end
    join
    chk_eq("ninth_accept", 32'(ok), 32'd1);
    compare_bytes("full", base);
    chk_eq("full_drain_count", 32'(fifo_count), 32'd0);

    // simultaneous push and pop at count 3, pointers wrapped by now
    base = got_q.size();
    hold_busy = 1'b1;
    for (int w = 0; w < 3; w++) push_exp(seq_word(8'hC0 + 4 * w));
    chk_eq("pp_count_before", 32'(fifo_count), 32'd3);
    @(negedge sys_clk);
    hold_busy = 1'b0;
    @(negedge sys_clk);
    chk_eq("pp_state_load", 32'(dbg_state), 32'(LOAD));
    s_valid = 1'b1;
    s_data  = seq_word(8'hCC);
    for (int b = 0; b < 4; b++) exp_q.push_back(8'(8'hCC + b));
    @(negedge sys_clk);
    s_valid = 1'b0;
    chk_eq("pp_count_same", 32'(fifo_count), 32'd3);
    compare_bytes("wrap", base);

    // busy high across reset release: no request until it falls
    base = got_q.size(); rbase = rises;
    hold_busy = 1'b1;
    @(negedge sys_clk);
    sys_rst = 1'b1;
    repeat (2) @(negedge sys_clk);
    sys_rst = 1'b0;
    @(negedge sys_clk);
    push_exp(32'h87654321);
    repeat (10) @(negedge sys_clk);
    chk_eq("busy_rel_rises", 32'(rises - rbase), 32'd0);
    chk_eq("busy_rel_state", 32'(dbg_state), 32'(IDLE));
    chk_eq("busy_rel_count", 32'(fifo_count), 32'd1);
    hold_busy = 1'b0;
    compare_bytes("busy_rel", base);

    // reset during the second byte of a word discards the rest
    base = got_q.size();
    push_exp(32'h11223344);
    exp_q.delete();
    exp_q.push_back(8'h44);
    exp_q.push_back(8'h33);
    for (int i = 0; i < 400 && got_q.size() < base + 2; i++) @(negedge sys_clk);
    sys_rst = 1'b1;
    @(negedge sys_clk);
    chk_eq("midrst_count", 32'(fifo_count), 32'd0);
    chk_eq("midrst_en", 32'(uart_en), 32'd0);
    chk_eq("midrst_ready", 32'(s_ready), 32'd0);
    chk_eq("midrst_idle", 32'(idle), 32'd1);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    @(negedge sys_clk);
    push_word(32'hA5A50F0F, 20, ok);
    chk_eq("midrst_push", 32'(ok), 32'd1);
    exp_q.push_back(8'h0F);
    exp_q.push_back(8'h0F);
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'hA5);
    compare_bytes("midrst", base);

    // back-to-back words: inter-word gap is two cycles longer than inter-byte
    base = got_q.size(); gbase = gap_q.size();
    push_exp(32'h00000000);
    push_exp(32'hFFFFFFFF);
    compare_bytes("b2b", base);
    chk_eq("b2b_nrises", 32'(gap_q.size() - gbase), 32'd8);
    if (gap_q.size() >= gbase + 8) begin
      chk_eq("b2b_byte_gap", 32'(gap_q[gbase + 1]), 32'd1);
      chk_eq("b2b_byte_gap2", 32'(gap_q[gbase + 3]), 32'd1);
      chk_eq("b2b_word_gap", 32'(gap_q[gbase + 4]), 32'd3);
    end
    chk_eq("end_idle", 32'(idle), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
